// File: rtl/fb_access_arbiter_if.sv
// Port bundle between the frame-buffer arbiter, its three users and the single-port RAM.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface fb_access_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 3
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              vblank;
    logic              w0_req;
    logic [ADDR_W-1:0] w0_addr;
    logic [DATA_W-1:0] w0_data;
    logic              w0_ack;
    logic              w1_req;
    logic [ADDR_W-1:0] w1_addr;
    logic [DATA_W-1:0] w1_data;
    logic              w1_ack;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, vblank,
        input  w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data,
        input  clr_start, clr_color, mem_rdata,
        output disp_data, disp_valid, w0_ack, w1_ack,
        output clr_busy, clr_done, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output disp_req, disp_addr, vblank,
        output w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data,
        output clr_start, clr_color, mem_rdata,
        input  disp_data, disp_valid, w0_ack, w1_ack,
        input  clr_busy, clr_done, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/fb_access_arbiter.sv
// Frame-buffer port arbiter: display read > clear engine > round-robin writers; writes issue 1 cycle
// after request, display data returns 3 cycles after disp_req; writers just wait (no ack) while stalled.
module fb_access_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 3,
    parameter int NUM_WORDS  = 19200,
    parameter int BLANK_ONLY = 0
) (
    input  logic               vga_clock,
    input  logic               reset,
    fb_access_arbiter_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              w0_ack_q, w0_ack_d;
    logic              w1_ack_q, w1_ack_d;
    logic              done_q, done_d;
    logic              last_q, last_d;
    logic              rd1_q, rd1_d;
    logic              rd2_q;
    logic              disp_valid_q;
    logic [DATA_W-1:0] disp_data_q;

    logic wr_en;
    logic elig0;
    logic elig1;
    logic grant1;

    always_comb begin
        wr_en  = (BLANK_ONLY == 0) || bus.vblank;
        // A writer that is seeing its ack this cycle is still presenting the old request.
        elig0  = bus.w0_req && !w0_ack_q;
        elig1  = bus.w1_req && !w1_ack_q;
        grant1 = elig1 && (!elig0 || !last_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        color_d     = color_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        w0_ack_d    = 1'b0;
        w1_ack_d    = 1'b0;
        done_d      = 1'b0;
        last_d      = last_q;
        rd1_d       = 1'b0;

        if (state_q == ST_IDLE && bus.clr_start) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            color_d = bus.clr_color;
        end
        // The done cycle still counts as busy; the engine only lets go on the next edge.
        if (state_q == ST_CLEAR && done_q) begin
            state_d = ST_IDLE;
        end

        if (bus.disp_req) begin
            rd1_d      = 1'b1;
            mem_addr_d = bus.disp_addr;
        end else if (wr_en) begin
            if (state_q == ST_CLEAR) begin
                if (!done_q) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = color_q;
                    cnt_d       = cnt_q + ADDR_W'(1);
                    done_d      = (cnt_q == LAST_ADDR);
                end
            end else if (!bus.clr_start && (elig0 || elig1)) begin
                mem_we_d = 1'b1;
                last_d   = grant1;
                if (grant1) begin
                    mem_addr_d  = bus.w1_addr;
                    mem_wdata_d = bus.w1_data;
                    w1_ack_d    = 1'b1;
                end else begin
                    mem_addr_d  = bus.w0_addr;
                    mem_wdata_d = bus.w0_data;
                    w0_ack_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            color_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            w0_ack_q     <= 1'b0;
            w1_ack_q     <= 1'b0;
            done_q       <= 1'b0;
            last_q       <= 1'b1;
            rd1_q        <= 1'b0;
            rd2_q        <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            color_q      <= color_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            w0_ack_q     <= w0_ack_d;
            w1_ack_q     <= w1_ack_d;
            done_q       <= done_d;
            last_q       <= last_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd1_q;
            disp_valid_q <= rd2_q;
            if (rd2_q) begin
                disp_data_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.w0_ack     = w0_ack_q;
    assign bus.w1_ack     = w1_ack_q;
    assign bus.clr_busy   = (state_q == ST_CLEAR);
    assign bus.clr_done   = done_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Shares one single-port frame-buffer RAM between three users: the VGA display read path, two game-logic pixel writers, and a built-in full-screen clear engine. The display read path always has priority, so scan-out never stalls. The two writers are served round-robin in the remaining cycles. The clear engine fills every word with one colour on request. The block sits between the VGA scan-out address logic and the tile-drawing logic, in the `vga_clock` domain.

## Interface
- `ADDR_W`, 15: frame-buffer address width.
- `DATA_W`, 3: colour depth in bits per word.
- `NUM_WORDS`, 19200: number of words (160x120) the clear engine fills.
- `BLANK_ONLY`, 0: when 1, writer and clear writes are issued only while `vblank`=1.

Ports:
- `vga_clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `disp_req` in 1: display read request, sampled every cycle.
- `disp_addr` in ADDR_W: display read address.
- `disp_data` out DATA_W: read data for the display.
- `disp_valid` out 1: `disp_data` is valid this cycle.
- `vblank` in 1: vertical blanking indicator.
- `w0_req` in 1, `w0_addr` in ADDR_W, `w0_data` in DATA_W: writer 0 request.
- `w0_ack` out 1: one-cycle pulse when writer 0's write is issued.
- `w1_req`, `w1_addr`, `w1_data`, `w1_ack`: the same as writer 0, for writer 1.
- `clr_start` in 1: start a full clear.
- `clr_color` in DATA_W: fill colour, latched at start.
- `clr_busy` out 1: clear in progress.
- `clr_done` out 1: one-cycle pulse when the clear completes.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_we` out 1: RAM port, all registered.
- `mem_rdata` in DATA_W: RAM read data, one cycle after `mem_addr` is presented.

## Operation
**States and transitions**
- IDLE: writers are arbitrated.
- CLEAR: writers are stalled.
- IDLE→CLEAR on `clr_start`=1. In that cycle no writer is granted and `clr_color` is latched. The word counter is set to 0.
- `clr_start` during CLEAR is ignored.

**Per-cycle arbitration, highest priority first**
1. `disp_req`=1: issue a read of `disp_addr` (`mem_we`=0). No write is issued this cycle.
2. CLEAR and write-enabled: write the latched colour to counter address, then increment the counter.
   - After the write of address NUM_WORDS-1: `clr_done` pulses in the same cycle as that `mem_we`. `clr_busy` drops and the state returns to IDLE on the following edge.
3. IDLE and write-enabled: choose among eligible writers.
   - A writer is eligible when `wN_req`=1 and `wN_ack`=0 in this cycle. This masks the cycle in which the requester is still reacting to its ack, so no double write occurs.
   - Both eligible: grant the writer not granted last. `last_grant` resets to 1, so w0 wins first.
   - Only one eligible: grant it. `last_grant` updates only on a grant.
4. Otherwise: `mem_we`=0 and `mem_addr` holds its value.

**Rules**
- Write-enabled = (`BLANK_ONLY`=0) or (`vblank`=1).
- Writers hold `req`, `addr` and `data` stable until their ack. A request may wait indefinitely while display or clear traffic is present.
- The counter is ADDR_W bits wide and never wraps. The clear ends exactly at NUM_WORDS-1.

## Timing
**Reset**
- All outputs are 0, the state is IDLE, the counter is 0, and `last_grant`=1.
- The display valid pipeline is flushed: no `disp_valid` for requests in flight.
- Reset mid-clear aborts the clear with no `clr_done`. Memory is left partially cleared.

**Writes**
- Request sampled at edge k: `mem_we`/`mem_addr`/`mem_wdata` and `wN_ack` are all high in cycle k+1 (registered).
- Minimum writer latency is 1 cycle. Back-to-back grants alternate every cycle when both writers are requesting.

**Display reads**
- `disp_req` sampled at edge k: `mem_addr` is presented in cycle k+1 and `mem_rdata` is valid in cycle k+2.
- `disp_data`/`disp_valid` are registered and asserted in cycle k+3. Fixed latency is 3; throughput is one read per cycle.

**Clear**
- `clr_busy` is high from the cycle after `clr_start` is sampled until `clr_done`, inclusive.
- With no display traffic and write-enabled, the clear takes NUM_WORDS cycles.

## Test plan
- **Display-only read:** pulse `disp_req` with `disp_addr`=100 while the RAM model holds 3'b101 at 100 → `disp_valid`=1 with `disp_data`=3'b101 exactly 3 cycles later. Continuous requests give one valid per cycle.
- **Writer contention:** hold both writers requesting, w0 to 10/3'b001 and w1 to 20/3'b010, with no `disp_req` → w0 acked first, then w1, then alternating. Requests are never acked in consecutive cycles.
- **Display preempts writes:** `disp_req` held high for 5 cycles while w0 requests → `w0_ack` stays 0 throughout. `w0_ack` arrives 1 cycle after `disp_req` drops.
- **Full clear:** `clr_start` with `clr_color`=3'b111 and no traffic, then assert w1 mid-clear.
  - All 19200 words are written with 3'b111 and `clr_done` pulses once.
  - `w1_ack` occurs only after `clr_busy` drops.
- **Blank-only gating:** with `BLANK_ONLY`=1 and `vblank`=0, w0 requests → no ack. Raising `vblank` produces the ack 1 cycle later.
- **Reset mid-clear:** assert `reset` at word 500 → all outputs are 0 next cycle, the state is IDLE, and no `clr_done` occurs. A new `clr_start` restarts the clear at address 0.
